// File: rtl/wb_gpio_pkg.sv
// Shared definitions for the Wishbone GPIO slave with edge interrupts.
// Holds the register offsets, decoded from adr[7:0], and the helper that
// expands Wishbone byte-lane selects into a 32-bit bit mask.
package wb_gpio_pkg;

  localparam logic [7:0] ADR_CTRL = 8'h00;
  localparam logic [7:0] ADR_IN   = 8'h10;
  localparam logic [7:0] ADR_OUT  = 8'h14;
  localparam logic [7:0] ADR_OE   = 8'h18;
  localparam logic [7:0] ADR_SET  = 8'h1C;
  localparam logic [7:0] ADR_CLR  = 8'h20;
  localparam logic [7:0] ADR_TGL  = 8'h24;
  localparam logic [7:0] ADR_RISE = 8'h28;
  localparam logic [7:0] ADR_FALL = 8'h2C;
  localparam logic [7:0] ADR_PEND = 8'h30;

  function automatic logic [31:0] sel_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{sel[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage synchroniser for asynchronous GPIO pin inputs.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   d_i        : WIDTH asynchronous inputs
//   q_o        : WIDTH inputs after STAGES flip-flops
module gpio_sync #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/wb_gpio_irq.sv
// Wishbone GPIO slave: per-bit output enable, atomic set/clear/toggle of
// outputs, synchronised inputs and per-bit rise/fall interrupt capture with
// write-1-to-clear pending bits, combined into one level interrupt.
// Ports:
//   clk, reset          : system clock, synchronous active-high reset
//   wb_*                : Wishbone slave (registered ack, one wait state)
//   intr                : gie & |pending, driven only from registers
//   gpio_in             : asynchronous pin inputs
//   gpio_out / gpio_oe  : pin output values / output enables (1 = drive)
module wb_gpio_irq
  import wb_gpio_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] OUT_RESET   = '0,
  parameter logic [31:0] OE_RESET    = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_stb_i,
  input  logic             wb_cyc_i,
  output logic             wb_ack_o,
  input  logic             wb_we_i,
  input  logic [31:0]      wb_adr_i,
  input  logic [3:0]       wb_sel_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  output logic             intr,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe
);

  logic             ack_q;
  logic [31:0]      dat_q;
  logic             gie_q, gie_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] oe_q, oe_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] sync_w;

  logic             take, wr;
  logic [7:0]       adr;
  logic [31:0]      bmask;
  logic [WIDTH-1:0] wmask, wsel, w1c;
  logic [31:0]      rdata;
  logic             unused_adr_hi;

  gpio_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (gpio_in),
    .q_o   (sync_w)
  );

  assign unused_adr_hi = ^wb_adr_i[31:8];
  assign adr   = wb_adr_i[7:0];
  assign take  = wb_stb_i & wb_cyc_i & ~ack_q;
  assign wr    = take & wb_we_i;
  assign bmask = sel_mask(wb_sel_i);
  assign wmask = bmask[WIDTH-1:0];
  assign wsel  = wb_dat_i[WIDTH-1:0] & wmask;

  always_comb begin
    gie_d     = gie_q;
    out_d     = out_q;
    oe_d      = oe_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c       = '0;
    if (wr) begin
      case (adr)
        ADR_CTRL: if (wb_sel_i[0]) gie_d = wb_dat_i[0];
        ADR_OUT:  out_d     = (out_q & ~wmask) | wsel;
        ADR_OE:   oe_d      = (oe_q & ~wmask) | wsel;
        ADR_SET:  out_d     = out_q | wsel;
        ADR_CLR:  out_d     = out_q & ~wsel;
        ADR_TGL:  out_d     = out_q ^ wsel;
        ADR_RISE: rise_en_d = (rise_en_q & ~wmask) | wsel;
        ADR_FALL: fall_en_d = (fall_en_q & ~wmask) | wsel;
        ADR_PEND: w1c       = wsel;
        default:  ;
      endcase
    end
    // New edge events are OR-ed in after the clear so an edge arriving with
    // a W1C of the same bit keeps it pending.
    pend_d = (pend_q & ~w1c)
           | (sync_w & ~prev_q & rise_en_q)
           | (~sync_w & prev_q & fall_en_q);
  end

  always_comb begin
    rdata = '0;
    case (adr)
      ADR_CTRL: begin
        rdata[0]    = gie_q;
        rdata[13:8] = 6'(WIDTH);
      end
      ADR_IN:   rdata[WIDTH-1:0] = sync_w;
      ADR_OUT:  rdata[WIDTH-1:0] = out_q;
      ADR_OE:   rdata[WIDTH-1:0] = oe_q;
      ADR_RISE: rdata[WIDTH-1:0] = rise_en_q;
      ADR_FALL: rdata[WIDTH-1:0] = fall_en_q;
      ADR_PEND: rdata[WIDTH-1:0] = pend_q;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      gie_q     <= 1'b0;
      out_q     <= OUT_RESET[WIDTH-1:0];
      oe_q      <= OE_RESET[WIDTH-1:0];
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
      prev_q    <= '0;
    end else begin
      ack_q     <= take;
      dat_q     <= take ? rdata : '0;
      gie_q     <= gie_d;
      out_q     <= out_d;
      oe_q      <= oe_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      pend_q    <= pend_d;
      prev_q    <= sync_w;
    end
  end

  // Write side effects happen on the take cycle, so a master dropping stb
  // before seeing ack still gets its write; ack itself is gated by stb&cyc.
  assign wb_ack_o = wb_stb_i & wb_cyc_i & ack_q;
  assign wb_dat_o = dat_q;
  assign intr     = gie_q & (|pend_q);
  assign gpio_out = out_q;
  assign gpio_oe  = oe_q;

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Directed self-checking bench for wb_gpio_irq (WIDTH=8, SYNC_STAGES=2,
// OUT_RESET=8'hA5). Inputs change 1 ns after the rising edge and outputs
// are sampled at that same point.
module tb_wb_gpio_irq;

  logic        clk;
  logic        reset;
  logic        stb, cyc, we;
  logic [31:0] adr, dat_w;
  logic [3:0]  sel;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;
  logic        intr;
  logic [7:0]  pins, gpio_out, gpio_oe;

  int checks = 0;
  int errors = 0;
  int unsigned last_waits;
  logic [31:0] rd;

  wb_gpio_irq #(
    .WIDTH       (8),
    .SYNC_STAGES (2),
    .OUT_RESET   (32'h0000_00A5),
    .OE_RESET    (32'h0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wb_stb_i (stb),
    .wb_cyc_i (cyc),
    .wb_ack_o (wb_ack_o),
    .wb_we_i  (we),
    .wb_adr_i (adr),
    .wb_sel_i (sel),
    .wb_dat_i (dat_w),
    .wb_dat_o (wb_dat_o),
    .intr     (intr),
    .gpio_in  (pins),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_cycle(input logic w, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rdat);
    stb = 1'b1; cyc = 1'b1; we = w; adr = {24'h0, a}; dat_w = d; sel = s;
    last_waits = 0;
    do begin
      step();
      last_waits++;
    end while (!wb_ack_o && last_waits < 8);
    if (!wb_ack_o) check("ack_timeout", 32'(wb_ack_o), 32'd1);
    rdat = wb_dat_o;
    stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = '0;
    step();
  endtask

  task automatic wb_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] dummy;
    wb_cycle(1'b1, a, d, s, dummy);
  endtask

  task automatic rd_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] v;
    wb_cycle(1'b0, a, 32'h0, 4'h0, v);
    check(tag, v, exp);
  endtask

  initial begin
    reset = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0;
    adr = '0; dat_w = '0; sel = '0; pins = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_ack",  32'(wb_ack_o), 32'd0);
    check("rst_intr", 32'(intr), 32'd0);
    check("rst_out",  32'(gpio_out), 32'h0000_00A5);
    check("rst_oe",   32'(gpio_oe), 32'h0);
    check("rst_dat",  wb_dat_o, 32'h0);
    rd_check("ctrl_rst", 8'h00, 32'h0000_0800);
    check("ack_wait", 32'(last_waits), 32'd1);
    rd_check("out_rst", 8'h14, 32'h0000_00A5);
    check("ack_wait2", 32'(last_waits), 32'd1);
    rd_check("oe_rst", 8'h18, 32'h0);
    rd_check("pend_rst", 8'h30, 32'h0);
    rd_check("unmapped", 8'h40, 32'h0);

    // Output register and atomic ops (only 8 bits implemented)
    wb_write(8'h14, 32'h0000_F0F0, 4'hF);
    check("out_wr", 32'(gpio_out), 32'h0000_00F0);
    wb_write(8'h1C, 32'h0000_000F, 4'hF);
    check("out_set", 32'(gpio_out), 32'h0000_00FF);
    wb_write(8'h20, 32'h0000_00F0, 4'hF);
    check("out_clr", 32'(gpio_out), 32'h0000_000F);
    wb_write(8'h24, 32'h0000_FFFF, 4'hF);
    check("out_tgl", 32'(gpio_out), 32'h0000_00F0);
    rd_check("out_rd", 8'h14, 32'h0000_00F0);
    rd_check("set_rd0", 8'h1C, 32'h0);
    wb_write(8'h14, 32'h0, 4'hF);
    wb_write(8'h14, 32'h1234_5678, 4'b0010);
    check("out_sel_hi", 32'(gpio_out), 32'h0);
    wb_write(8'h14, 32'h1234_5678, 4'b0001);
    check("out_sel_lo", 32'(gpio_out), 32'h0000_0078);
    wb_write(8'h14, 32'h0000_00FF, 4'b0000);
    check("out_sel_none", 32'(gpio_out), 32'h0000_0078);
    wb_write(8'h18, 32'h0000_003C, 4'b0001);
    check("oe_wr", 32'(gpio_oe), 32'h0000_003C);

    // Rising edge interrupt on bit 0, latency SYNC_STAGES+1
    wb_write(8'h28, 32'h1, 4'hF);
    wb_write(8'h00, 32'h1, 4'hF);
    rd_check("ctrl_gie", 8'h00, 32'h0000_0801);
    pins = 8'h01;
    step(); check("intr_t1", 32'(intr), 32'd0);
    step(); check("intr_t2", 32'(intr), 32'd0);
    step(); check("intr_t3", 32'(intr), 32'd1);
    rd_check("pend_rise", 8'h30, 32'h1);
    rd_check("in_bit0", 8'h10, 32'h1);
    wb_write(8'h30, 32'h1, 4'hF);
    check("intr_w1c", 32'(intr), 32'd0);
    rd_check("pend_w1c", 8'h30, 32'h0);

    // Input visibility after exactly two stages (bit 1, edge irq disabled)
    pins = 8'h03;
    step();
    rd_check("in_early", 8'h10, 32'h1);
    rd_check("in_late", 8'h10, 32'h3);
    rd_check("pend_dis_rise", 8'h30, 32'h0);

    // Falling edge on bit 3: discarded while disabled, captured once enabled
    pins = 8'h0B; repeat (4) step();
    pins = 8'h03; repeat (4) step();
    rd_check("pend_fall_dis", 8'h30, 32'h0);
    wb_write(8'h2C, 32'h8, 4'hF);
    pins = 8'h0B; repeat (4) step();
    pins = 8'h03; repeat (4) step();
    rd_check("pend_fall", 8'h30, 32'h8);
    check("intr_fall", 32'(intr), 32'd1);
    wb_write(8'h00, 32'h0, 4'hF);
    check("intr_gie0", 32'(intr), 32'd0);
    rd_check("pend_gie0", 8'h30, 32'h8);
    wb_write(8'h2C, 32'h0, 4'hF);
    rd_check("pend_en_clr", 8'h30, 32'h8);
    wb_write(8'h30, 32'h8, 4'h0);
    rd_check("pend_w1c_nosel", 8'h30, 32'h8);
    wb_write(8'h30, 32'hFF, 4'h1);
    rd_check("pend_w1c_sel", 8'h30, 32'h0);

    // W1C on bit 0 lands on the same edge as a new rise: event wins
    pins = 8'h02; repeat (4) step();
    pins = 8'h03;
    step(); step();
    wb_write(8'h30, 32'h1, 4'hF);
    rd_check("pend_race", 8'h30, 32'h1);
    wb_write(8'h00, 32'h1, 4'hF);
    check("intr_race", 32'(intr), 32'd1);

    // Reset during a pending write access
    reset = 1'b1; stb = 1'b1; cyc = 1'b1; we = 1'b1;
    adr = 32'h14; dat_w = 32'h55; sel = 4'hF;
    step();
    check("rst_mid_ack",  32'(wb_ack_o), 32'd0);
    check("rst_mid_out",  32'(gpio_out), 32'h0000_00A5);
    check("rst_mid_oe",   32'(gpio_oe), 32'h0);
    check("rst_mid_intr", 32'(intr), 32'd0);
    check("rst_mid_dat",  wb_dat_o, 32'h0);
    stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = '0;
    reset = 1'b0;
    step();
    rd_check("rst_mid_ctrl", 8'h00, 32'h0000_0800);
    rd_check("rst_mid_rise", 8'h28, 32'h0);
    rd_check("rst_mid_pend", 8'h30, 32'h0);
    rd_check("rst_mid_in", 8'h10, 32'h3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_gpio_irq.md
Name: wb_gpio_irq

Overview:
Parametrised next-generation Wishbone GPIO slave: WIDTH pins with per-bit output enable and atomic set/clear/toggle of outputs. Adds input synchronisation and per-bit rising/falling edge interrupt capture with write-1-to-clear pending bits, combined into one level interrupt line. Sits on the SoC peripheral Wishbone bus beside the other wb_* slaves; intr goes to the CPU interrupt controller.

Parameters:
WIDTH, 32, number of GPIO pins (1..32); register bits above WIDTH read 0 and ignore writes
SYNC_STAGES, 2, flip-flop stages on gpio_in before any use (2..4)
OUT_RESET, 0, reset value of gpio_out[WIDTH-1:0]
OE_RESET, 0, reset value of gpio_oe[WIDTH-1:0]

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high
wb_stb_i  input  1  Wishbone strobe
wb_cyc_i  input  1  Wishbone cycle
wb_ack_o  output  1  Wishbone acknowledge
wb_we_i  input  1  write enable
wb_adr_i  input  32  byte address; only [7:0] decoded
wb_sel_i  input  4  byte lane selects
wb_dat_i  input  32  write data
wb_dat_o  output  32  read data
intr  output  1  level interrupt, active-high
gpio_in  input  WIDTH  asynchronous pin inputs
gpio_out  output  WIDTH  pin output values
gpio_oe  output  WIDTH  pin output enables, 1 = drive

Behaviour:
- Clock clk; reset is synchronous, active-high. On reset: ack=0, wb_dat_o=0, gpio_out=OUT_RESET, gpio_oe=OE_RESET, irq_rise=irq_fall=pend=0, gie=0, sync chain and edge history=0. Hence wb_ack_o=0 and intr=0 out of reset.
- Register map (adr[7:0]):
  0x00 CTRL: [0] gie (RW), [13:8] WIDTH (RO), other bits 0.
  0x10 IN (RO): synchronised inputs.
  0x14 OUT (RW). 0x18 OE (RW).
  0x1C OUT_SET, 0x20 OUT_CLR, 0x24 OUT_TGL (WO, read 0): OUT |= d, &= ~d, ^= d.
  0x28 IRQ_RISE (RW), 0x2C IRQ_FALL (RW): per-bit edge enables.
  0x30 PEND (R/W1C). Unmapped addresses read 0; writes to them are ignored.
- Handshake: one access per cycle. Access is taken when stb&cyc&~ack. Registered ack is 1 for exactly one cycle. wb_ack_o = stb&cyc&ack, giving 1-cycle wait state and 2-cycle minimum per access. wb_dat_o is registered with ack. Dropping stb mid-access still completes the internal write.
- wb_sel_i applies per byte lane on every write: OUT, OE, IRQ_*, CTRL, the SET/CLR/TGL data, and W1C data. An unselected byte has no effect.
- Synchroniser: pin change is visible in IN after SYNC_STAGES clocks. edge history prev <= sync every cycle. rise = sync&~prev; fall = ~sync&prev.
- Pending: pend_next = (pend & ~w1c_mask) | (rise&irq_rise) | (fall&irq_fall). An edge in the same cycle as a W1C of that bit leaves the bit set (event wins). Edges on disabled bits are discarded, never latched. Clearing an enable does not clear pend.
- intr = gie & |pend, driven from registers with no combinational path from bus inputs. Pin edge to intr latency = SYNC_STAGES+1 cycles.
- Pulses shorter than one clk after synchronisation are not guaranteed to be captured.
- Reading PEND has no side effect.

Decomposition:
- Package wb_gpio_pkg: register offset localparams (ADR_CTRL, ADR_IN, ADR_OUT, ADR_OE, ADR_SET, ADR_CLR, ADR_TGL, ADR_RISE, ADR_FALL, ADR_PEND) and a byte-lane mask function turning sel into a 32-bit mask.
- Sub-module gpio_sync: WIDTH-wide, SYNC_STAGES-deep synchroniser with synchronous reset. Everything else stays in wb_gpio_irq.

Test Plan:
- Reset then read 0x00/0x14/0x18 with WIDTH=8, OUT_RESET=8'hA5 -> 0x00000800, 0x000000A5, 0x00000000; intr=0; each ack after exactly 1 wait cycle.
- OUT=0xF0F0; OUT_SET 0x000F; OUT_CLR 0x00F0; OUT_TGL 0xFFFF -> gpio_out goes 0xF0FF, then 0xF00F, then 0x0FF0. Write 0x14 data 0x12345678 with sel=4'b0010 from 0 -> OUT=0x00005600.
- IRQ_RISE=0x1, gie=1; gpio_in[0] 0->1 at cycle t -> IN[0]=1 at t+2 (SYNC_STAGES=2); PEND=0x1 and intr=1 at t+3; W1C 0x1 -> intr=0 the cycle after ack.
- Falling edge on bit 3 with IRQ_FALL=0 -> PEND stays 0. Set IRQ_FALL[3] and toggle again -> PEND=0x8. gie=0 -> intr=0 while PEND stays 0x8.
- W1C of bit 0 issued in the same cycle a new enabled rising edge on bit 0 reaches pend logic -> PEND[0] remains 1.
- Reset asserted mid-access, with stb held and ack pending -> no ack the next cycle, all registers at reset values.
